// File: rtl/rnn_gains_tx_pkg.sv
// Shared constants, state encoding and frame helpers for the RNN gains transmitter.
// HDR_BYTE must stay in step with the receiver's frame decoder.
package rnn_gains_tx_pkg;

  localparam int unsigned FLOAT     = 32;
  localparam int unsigned NUM_GAINS = 22;
  localparam logic [7:0]  HDR_BYTE  = 8'hA5;

  localparam int unsigned BPW    = FLOAT / 8;
  localparam int unsigned WORDS  = NUM_GAINS + 1;
  localparam int unsigned VEC_W  = WORDS * FLOAT;
  localparam int unsigned GAIN_W = NUM_GAINS * FLOAT;
  localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BPW - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StData = 2'd2,
    StCsum = 2'd3
  } state_e;

  function automatic int unsigned frame_len();
    return 2 + WORDS * BPW;
  endfunction

endpackage

// File: rtl/rnn_gains_tx_if.sv
// Result-in and byte-out handshake bundle for rnn_gains_tx.
interface rnn_gains_tx_if;
  import rnn_gains_tx_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [GAIN_W-1:0] gains;
  logic [FLOAT-1:0]  vad;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_valid, gains, vad, tx_ready,
    input  in_ready, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    input  in_valid, gains, vad, tx_ready,
    output in_ready, tx_data, tx_valid, busy, frame_done
  );

endinterface

// File: rtl/rnn_word_byte_sel.sv
// Picks byte byte_idx_i of word word_idx_i from the latched {gains, vad} vector.
module rnn_word_byte_sel
  import rnn_gains_tx_pkg::*;
(
  input  logic [VEC_W-1:0]  vec_i,
  input  logic [WORD_W-1:0] word_idx_i,
  input  logic [BYTE_W-1:0] byte_idx_i,
  output logic [7:0]        byte_o
);

  logic [31:0]      bit_pos;
  logic [VEC_W-1:0] shifted;

  always_comb begin
    bit_pos = (32'(word_idx_i) * BPW + 32'(byte_idx_i)) << 3;
    shifted = vec_i >> bit_pos;
    byte_o  = shifted[7:0];
  end

endmodule

// File: rtl/rnn_gains_tx.sv
// Frames one latched RNN result as header, vad, gains (LSB first) and XOR checksum bytes.
module rnn_gains_tx
  import rnn_gains_tx_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  rnn_gains_tx_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [7:0]        csum_q, csum_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              tx_valid_q, tx_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        sel_byte;
  logic              tx_fire;

  rnn_word_byte_sel u_sel (
    .vec_i      (vec_q),
    .word_idx_i (word_q),
    .byte_idx_i (byte_q),
    .byte_o     (sel_byte)
  );

  assign tx_fire = tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_d       = byte_q;
    csum_d       = csum_q;
    vec_d        = vec_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          vec_d      = {bus.gains, bus.vad};
          csum_d     = 8'h00;
          word_d     = '0;
          byte_d     = '0;
          state_d    = StHdr;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
        end
      end
      StHdr: begin
        if (tx_fire) begin
          state_d = StData;
          word_d  = '0;
          byte_d  = '0;
        end
      end
      StData: begin
        if (tx_fire) begin
          csum_d = csum_q ^ sel_byte;
          if (byte_q == BYTE_LAST) begin
            byte_d = '0;
            if (word_q == WORD_LAST) begin
              state_d = StCsum;
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      StCsum: begin
        if (tx_fire) begin
          state_d      = StIdle;
          tx_valid_d   = 1'b0;
          busy_d       = 1'b0;
          in_ready_d   = 1'b1;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      word_q       <= '0;
      byte_q       <= '0;
      csum_q       <= 8'h00;
      vec_q        <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_q       <= byte_d;
      csum_q       <= csum_d;
      vec_q        <= vec_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Data is a pure function of registered state, so it holds steady through tx_ready stalls.
  always_comb begin
    bus.tx_data = 8'h00;
    unique case (state_q)
      StHdr:   bus.tx_data = HDR_BYTE;
      StData:  bus.tx_data = sel_byte;
      StCsum:  bus.tx_data = csum_q;
      default: bus.tx_data = 8'h00;
    endcase
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_rnn_gains_tx.sv
// Directed bench for rnn_gains_tx: a frame-level byte-queue model checked every cycle,
// plus literal expectations for the documented frames.
module tb_rnn_gains_tx;
  import rnn_gains_tx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rnn_gains_tx_if bus ();

  rnn_gains_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int csum_cyc = 0;
  int gap = 0;
  bit rnd_ready = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];

  // Model state: what the outputs must be on the next sample.
  bit         m_busy = 1'b0;
  bit         m_rdy = 1'b0;
  bit         m_done = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame: header, vad then gains LSB first, XOR of the payload bytes.
  task automatic model_push(input logic [FLOAT-1:0] v, input logic [GAIN_W-1:0] g);
    logic [VEC_W-1:0] vec;
    logic [7:0] b;
    logic [7:0] cs;
    vec = {g, v};
    cs  = 8'h00;
    exp_q.push_back(HDR_BYTE);
    for (int w = 0; w < int'(WORDS); w++) begin
      for (int i = 0; i < int'(BPW); i++) begin
        b  = 8'(vec >> (8 * (w * int'(BPW) + i)));
        cs = cs ^ b;
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(cs);
  endtask

  function automatic logic [GAIN_W-1:0] ramp_gains(input logic [31:0] base);
    logic [GAIN_W-1:0] g;
    g = '0;
    for (int k = int'(NUM_GAINS) - 1; k >= 0; k--) g = (g << FLOAT) | GAIN_W'(base + 32'(k));
    return g;
  endfunction

  function automatic logic [GAIN_W-1:0] rand_gains();
    logic [GAIN_W-1:0] g;
    g = '0;
    for (int k = 0; k < int'(NUM_GAINS); k++) g = (g << FLOAT) | GAIN_W'($urandom);
    return g;
  endfunction

  always @(negedge clk) begin
    bit fire;
    bit last;
    bit accept;
    logic [7:0] eb;
    cyc++;
    if (!rst_n) begin
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      exp_q.delete();
      m_busy = 1'b0;
      m_rdy = 1'b0;
      m_done = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("tx_valid", 32'(bus.tx_valid), 32'(m_busy));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      check("frame_done", 32'(bus.frame_done), 32'(m_done));
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev) check("stall_hold", 32'(bus.tx_data), 32'(stall_data));
      fire = m_busy && bus.tx_ready;
      last = 1'b0;
      if (fire) begin
        got_q.push_back(bus.tx_data);
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(eb));
          last = (exp_q.size() == 0);
        end
      end
      stall_prev = m_busy && !bus.tx_ready;
      stall_data = bus.tx_data;
      accept = m_rdy && bus.in_valid;
      if (accept) begin
        model_push(bus.vad, bus.gains);
        acc_cnt++;
        acc_cyc = cyc;
        gap = cyc - csum_cyc;
      end
      if (last) csum_cyc = cyc;
      m_done = last;
      if (accept) m_busy = 1'b1;
      else if (last) m_busy = 1'b0;
      m_rdy = !m_busy;
    end
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.tx_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FLOAT-1:0] v, input logic [GAIN_W-1:0] g);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 1'b0;
    bus.vad = v;
    bus.gains = g;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    #1 bus.in_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt >= target) break;
      tick(1);
    end
    check("done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    logic [7:0] lit9 [9];
    logic [7:0] x;
    int d0;
    int a0;
    int nz;
    lit9 = '{8'hA5, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h03, 8'h02, 8'h01};
    bus.in_valid = 1'b0;
    bus.vad = '0;
    bus.gains = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Single frame, tx_ready high.
    got_q.delete();
    d0 = done_cnt;
    send(32'h3F80_0000, ramp_gains(32'h0102_0300));
    wait_done(d0 + 1);
    tick(3);
    check("frame_len", 32'(got_q.size()), frame_len());
    for (int i = 0; i < 9; i++) check("lead_bytes", 32'(got_q[i]), 32'(lit9[i]));
    x = 8'h00;
    for (int i = 1; i <= 92; i++) x = x ^ got_q[i];
    check("csum_xor", 32'(got_q[93]), 32'(x));
    check("csum_literal", 32'(got_q[93]), 32'h0000_00BE);
    check("done_latency", 32'(done_cyc - acc_cyc), 32'd95);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    ref_q = got_q;

    // Same frame with random tx_ready stalls.
    got_q.delete();
    rnd_ready = 1'b1;
    d0 = done_cnt;
    send(32'h3F80_0000, ramp_gains(32'h0102_0300));
    wait_done(d0 + 1);
    rnd_ready = 1'b0;
    tick(3);
    check("stall_len", 32'(got_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size(); i++) check("stall_seq", 32'(got_q[i]), 32'(ref_q[i]));

    // in_valid held high with changing data: two back-to-back frames.
    a0 = acc_cnt;
    d0 = done_cnt;
    bus.vad = 32'h1000_0000;
    bus.gains = rand_gains();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (acc_cnt >= a0 + 2) begin
        bus.in_valid = 1'b0;
        break;
      end
      bus.vad = 32'h1000_0000 + 32'(i);
      bus.gains = rand_gains();
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    check("b2b_gap", 32'(gap), 32'd1);
    wait_done(d0 + 2);
    tick(3);

    // All-zero frame.
    got_q.delete();
    d0 = done_cnt;
    send('0, '0);
    wait_done(d0 + 1);
    tick(2);
    check("zero_len", 32'(got_q.size()), 32'd94);
    check("zero_hdr", 32'(got_q[0]), 32'h0000_00A5);
    nz = 0;
    for (int i = 1; i < got_q.size(); i++) if (got_q[i] != 8'h00) nz++;
    check("zero_payload", 32'(nz), 32'd0);

    // Reset at byte 40, then a fresh frame.
    got_q.delete();
    d0 = done_cnt;
    send(32'h1234_5678, ramp_gains(32'hA0B0_C000));
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= 40) break;
      tick(1);
    end
    check("reached_byte40", 32'(got_q.size()), 32'd40);
    rst_n = 1'b0;
    #1;
    check("async_tx_valid_drop", 32'(bus.tx_valid), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    got_q.delete();
    send(32'hDEAD_BEEF, ramp_gains(32'h0000_0000));
    wait_done(d0 + 1);
    tick(2);
    check("restart_b0", 32'(got_q[0]), 32'h0000_00A5);
    check("restart_b1", 32'(got_q[1]), 32'h0000_00EF);
    check("restart_b2", 32'(got_q[2]), 32'h0000_00BE);
    check("restart_b3", 32'(got_q[3]), 32'h0000_00AD);
    check("restart_b4", 32'(got_q[4]), 32'h0000_00DE);

    // in_valid pulse while busy is ignored.
    a0 = acc_cnt;
    d0 = done_cnt;
    send(32'h5555_AAAA, ramp_gains(32'h0F0F_0000));
    tick(10);
    bus.vad = 32'h7777_7777;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    wait_done(d0 + 1);
    tick(20);
    check("pulse_accepts", 32'(acc_cnt - a0), 32'd1);
    check("pulse_frames", 32'(done_cnt - d0), 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rnn_gains_tx.md
Name: rnn_gains_tx

Overview:
- Transmit-side counterpart to the byte receiver that feeds feature vectors into the RNN top.
- Latches one RNN result (NUM_GAINS float gains plus the vad float) through a valid/ready handshake.
- Serialises the result into a framed byte stream on a valid/ready byte interface that drives the UART transmitter.
- Frame format: header byte, vad word, gain words 0..NUM_GAINS-1, XOR checksum byte. Each word is sent least-significant byte first.

Parameters:
- FLOAT, 32, bit width of one float word; must be a multiple of 8.
- NUM_GAINS, 22, number of gain words per frame.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  gains/vad present and stable.
- in_ready  output  1  block can accept a new result.
- gains  input  NUM_GAINS*FLOAT  gain k at bits [(k+1)*FLOAT-1 : k*FLOAT].
- vad  input  FLOAT  voice-activity float.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts byte.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (async on rst_n low):
  - All outputs low; in_ready goes high on the first clock after release.
  - State returns to IDLE; counters, checksum and latch registers clear.
- Constants:
  - BPW = FLOAT/8.
  - WORDS = NUM_GAINS+1.
  - Frame length = 2 + WORDS*BPW bytes (94 at defaults).
- States: IDLE, HDR, DATA, CSUM.
- IDLE:
  - in_ready = 1, busy = 0, tx_valid = 0.
  - On in_valid && in_ready, latch {gains, vad} into a shadow register, clear the checksum and counters, and go to HDR.
  - The header byte appears on tx_data with tx_valid high in the cycle after acceptance.
- HDR:
  - tx_data = HDR_BYTE, tx_valid = 1.
  - On tx_ready, go to DATA with word_idx = 0 and byte_idx = 0.
  - The header is not included in the checksum.
- DATA:
  - word_idx 0 selects vad; word_idx k ≥ 1 selects gain k-1.
  - tx_data = bits [8*byte_idx+7 : 8*byte_idx] of the selected latched word.
  - On each tx_ready: checksum ^= tx_data; byte_idx increments.
  - When byte_idx = BPW-1, byte_idx wraps to 0 and word_idx increments.
  - After byte BPW-1 of word WORDS-1 is accepted, go to CSUM.
- CSUM:
  - tx_data = checksum register (XOR of all vad and gain bytes).
  - On tx_ready, go to IDLE and pulse frame_done in the following cycle.
- Handshake rules:
  - A byte transfers only when tx_valid && tx_ready are both high.
  - tx_valid never deasserts and tx_data never changes until the byte is accepted.
  - tx_ready stalls of any length are legal.
- busy = 1 in HDR, DATA and CSUM.
- in_ready = 0 whenever busy; in_valid during busy is ignored, with no queuing.
- Back-to-back frames: in_ready rises in the cycle after the checksum is accepted, so the minimum gap is one IDLE cycle between frames.
- Input changes after acceptance have no effect on the frame in flight (shadow register).
- Reset mid-frame: the frame aborts immediately, tx_valid drops asynchronously, no frame_done pulse is produced, and the next frame starts from the header.
- Throughput with tx_ready tied high: one byte per cycle; frame_done occurs 95 cycles after acceptance at defaults.

Decomposition:
- Shared package holds:
  - FLOAT width constant and NUM_GAINS.
  - HDR_BYTE, which must match the receiver's frame decoder.
  - State encoding localparams.
  - Frame-length function 2+(NUM_GAINS+1)*(FLOAT/8).
- One natural sub-module, rnn_word_byte_sel: a combinational mux that selects a byte from the latched vector by (word_idx, byte_idx).
- The FSM, counters and checksum stay in rnn_gains_tx.

Test Plan:
- Single frame, tx_ready = 1; vad = 32'h3F800000, gain k = 32'h01020300 + k.
  - Required: 94 bytes.
  - Bytes 0..4 are A5, 00, 00, 80, 3F.
  - Bytes 5..8 are 00, 03, 02, 01.
  - Last byte is the XOR of bytes 1..92.
  - frame_done is seen once, 95 cycles after acceptance.
- Random tx_ready stalls (about 50% duty) on the same frame.
  - Required: identical byte sequence to the previous scenario.
  - tx_data is stable during every stall.
  - No byte is dropped or duplicated.
- in_valid held high continuously with changing data.
  - Required: in_ready is low throughout the frame.
  - Second frame starts exactly 1 cycle after the previous checksum handshake and carries the data present at that acceptance.
- All-zero inputs.
  - Required: A5, 92 zero bytes, checksum 00.
- rst_n asserted at byte 40 of a frame, released 3 cycles later, then a new frame with vad = 32'hDEADBEEF.
  - Required: tx_valid is 0 during reset and no frame_done occurs.
  - New frame begins A5, EF, BE, AD, DE.
- in_valid pulsed while busy.
  - Required: the pulse is ignored; only one frame is emitted.
